// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: controller states, per-register control pairs, NOP encoding.
package common_def;

  localparam int unsigned REG_ADDR_W = 4;

  // Instruction word loaded by a cleared pipeline register (addi x0, x0, 0)
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic we;
    logic clear;
  } reg_ctrl_t;

  typedef struct packed {
    reg_ctrl_t fd;
    reg_ctrl_t de;
    reg_ctrl_t ec;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t PIPE_ALL_WE = pipe_ctrl_t'(6'b10_10_10);
  localparam pipe_ctrl_t PIPE_FROZEN = pipe_ctrl_t'(6'b00_00_00);

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard detect: a load in execute whose destination is read by decode.
// Purely combinational; register 0 is treated like any other register.
module load_use_detect
  import common_def::*;
(
  input  logic                  load_X,
  input  logic [REG_ADDR_W-1:0] dest_X,
  input  logic [REG_ADDR_W-1:0] src_a_D,
  input  logic                  src_a_vld_D,
  input  logic [REG_ADDR_W-1:0] src_b_D,
  input  logic                  src_b_vld_D,
  output logic                  stall_lu
);

  assign stall_lu = load_X && ((src_a_vld_D && (src_a_D == dest_X)) ||
                               (src_b_vld_D && (src_b_D == dest_X)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the FD/DE/EC pipeline: memory waits, load-use bubbles,
// branch squashes, halt, memory-timeout flag and saturating stall counter.
module pipe_hazard_ctrl
  import common_def::*;
#(
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_X,
  input  logic [REG_ADDR_W-1:0]  dest_X,
  input  logic [REG_ADDR_W-1:0]  src_a_D,
  input  logic                   src_a_vld_D,
  input  logic [REG_ADDR_W-1:0]  src_b_D,
  input  logic                   src_b_vld_D,
  input  logic                   branch_taken_X,
  input  logic                   mem_req_C,
  input  logic                   mem_ready,
  input  logic                   halt_C,
  input  logic                   resume,
  output logic                   pc_write_enable,
  output logic                   write_enable_FD,
  output logic                   write_enable_DE,
  output logic                   write_enable_EC,
  output logic                   clear_FD,
  output logic                   clear_DE,
  output logic                   clear_EC,
  output logic                   halted,
  output logic                   mem_timeout_err,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  ctrl_state_t            state_q, state_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic                   err_q, err_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic       stall_lu;
  logic       pc_we_c;
  pipe_ctrl_t ctl_c;

  load_use_detect u_load_use_detect (
    .load_X      (load_X),
    .dest_X      (dest_X),
    .src_a_D     (src_a_D),
    .src_a_vld_D (src_a_vld_D),
    .src_b_D     (src_b_D),
    .src_b_vld_D (src_b_vld_D),
    .stall_lu    (stall_lu)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    pc_we_c    = 1'b0;
    ctl_c      = PIPE_FROZEN;
    unique case (state_q)
      RUN: begin
        pc_we_c = 1'b1;
        ctl_c   = PIPE_ALL_WE;
        if (halt_C) begin
          // Let the HALT retire through EC while squashing younger work
          pc_we_c        = 1'b0;
          ctl_c.fd.we    = 1'b0;
          ctl_c.fd.clear = 1'b1;
          ctl_c.de.clear = 1'b1;
          state_d        = HALT;
        end else if (mem_req_C && !mem_ready) begin
          pc_we_c    = 1'b0;
          ctl_c      = PIPE_FROZEN;
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else if (branch_taken_X) begin
          ctl_c.fd.clear = 1'b1;
          ctl_c.de.clear = 1'b1;
        end else if (stall_lu) begin
          pc_we_c        = 1'b0;
          ctl_c.fd.we    = 1'b0;
          ctl_c.de.clear = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          pc_we_c = 1'b1;
          ctl_c   = PIPE_ALL_WE;
          state_d = RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = HALT;
            err_d   = 1'b1;
          end
        end
      end
      HALT: begin
        if (resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Halt cycles are not stalls; the counter sticks at all-ones
  always_comb begin
    stall_d = stall_q;
    if (!pc_we_c && (state_q != HALT) && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  assign pc_write_enable = pc_we_c        && !rst;
  assign write_enable_FD = ctl_c.fd.we    && !rst;
  assign write_enable_DE = ctl_c.de.we    && !rst;
  assign write_enable_EC = ctl_c.ec.we    && !rst;
  assign clear_FD        = ctl_c.fd.clear && !rst;
  assign clear_DE        = ctl_c.de.clear && !rst;
  assign clear_EC        = ctl_c.ec.clear && !rst;

  assign halted          = (state_q == HALT);
  assign mem_timeout_err = err_q;
  assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed control vectors and counter values.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_X = 1'b0;
  logic [3:0]  dest_X = 4'h0;
  logic [3:0]  src_a_D = 4'h0;
  logic        src_a_vld_D = 1'b0;
  logic [3:0]  src_b_D = 4'h0;
  logic        src_b_vld_D = 1'b0;
  logic        branch_taken_X = 1'b0;
  logic        mem_req_C = 1'b0;
  logic        mem_ready = 1'b0;
  logic        halt_C = 1'b0;
  logic        resume = 1'b0;
  logic        pc_write_enable, write_enable_FD, write_enable_DE, write_enable_EC;
  logic        clear_FD, clear_DE, clear_EC, halted, mem_timeout_err;
  logic [15:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  // {pc_we, we_FD, we_DE, we_EC, clear_FD, clear_DE, clear_EC}
  localparam logic [6:0] C_ALL  = 7'b1111_000;
  localparam logic [6:0] C_ZERO = 7'b0000_000;
  localparam logic [6:0] C_HALT = 7'b0011_110;
  localparam logic [6:0] C_BR   = 7'b1111_110;
  localparam logic [6:0] C_LU   = 7'b0011_010;

  wire [6:0] ctl = {pc_write_enable, write_enable_FD, write_enable_DE, write_enable_EC,
                    clear_FD, clear_DE, clear_EC};

  pipe_hazard_ctrl #(.MEM_TIMEOUT(8), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .load_X(load_X), .dest_X(dest_X),
    .src_a_D(src_a_D), .src_a_vld_D(src_a_vld_D),
    .src_b_D(src_b_D), .src_b_vld_D(src_b_vld_D),
    .branch_taken_X(branch_taken_X),
    .mem_req_C(mem_req_C), .mem_ready(mem_ready),
    .halt_C(halt_C), .resume(resume),
    .pc_write_enable(pc_write_enable),
    .write_enable_FD(write_enable_FD), .write_enable_DE(write_enable_DE),
    .write_enable_EC(write_enable_EC),
    .clear_FD(clear_FD), .clear_DE(clear_DE), .clear_EC(clear_EC),
    .halted(halted), .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    load_X = 1'b0; dest_X = 4'h0; src_a_D = 4'h0; src_a_vld_D = 1'b0;
    src_b_D = 4'h0; src_b_vld_D = 1'b0; branch_taken_X = 1'b0;
    mem_req_C = 1'b0; mem_ready = 1'b0; halt_C = 1'b0; resume = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ctl", 32'(ctl), 32'(C_ZERO));
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_err", 32'(mem_timeout_err), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    tick(); tick();
    rst = 1'b0;

    // No hazards for 10 cycles
    for (int i = 0; i < 10; i++) begin
      mid();
      chk($sformatf("idle_ctl%0d", i), 32'(ctl), 32'(C_ALL));
      tick();
    end
    chk("idle_stall", 32'(stall_cycles), 32'd0);

    // Load-use on source B
    load_X = 1'b1; dest_X = 4'h3; src_b_D = 4'h3; src_b_vld_D = 1'b1;
    mid();  chk("lu_b_ctl", 32'(ctl), 32'(C_LU));
    tick(); chk("lu_b_stall", 32'(stall_cycles), 32'd1);

    // Same registers but source not read: no hazard
    src_b_vld_D = 1'b0;
    mid();  chk("lu_novld_ctl", 32'(ctl), 32'(C_ALL));
    tick();

    // Register 0 match on source A still stalls
    dest_X = 4'h0; src_a_D = 4'h0; src_a_vld_D = 1'b1;
    mid();  chk("lu_r0_ctl", 32'(ctl), 32'(C_LU));
    tick(); chk("lu_r0_stall", 32'(stall_cycles), 32'd2);

    // Matching sources without a load
    load_X = 1'b0;
    mid();  chk("lu_noload_ctl", 32'(ctl), 32'(C_ALL));
    tick();

    // Branch beats load-use
    load_X = 1'b1; branch_taken_X = 1'b1;
    mid();  chk("br_lu_ctl", 32'(ctl), 32'(C_BR));
    tick(); chk("br_lu_stall", 32'(stall_cycles), 32'd2);
    idle_inputs();

    // Memory wait: request cycle plus 3 waiting cycles, then ready
    mem_req_C = 1'b1;
    mid();  chk("mem_req_ctl", 32'(ctl), 32'(C_ZERO));
    tick();
    for (int i = 0; i < 3; i++) begin
      branch_taken_X = (i == 1);
      mid();  chk($sformatf("mem_wait_ctl%0d", i), 32'(ctl), 32'(C_ZERO));
      tick();
    end
    branch_taken_X = 1'b0;
    mem_ready = 1'b1;
    mid();  chk("mem_ready_ctl", 32'(ctl), 32'(C_ALL));
    tick(); chk("mem_stall", 32'(stall_cycles), 32'd6);
    chk("mem_halted", 32'(halted), 32'd0);
    idle_inputs();

    // Timeout: ready never arrives
    mem_req_C = 1'b1;
    mid();  chk("to_req_ctl", 32'(ctl), 32'(C_ZERO));
    tick();
    for (int i = 0; i < 8; i++) begin
      mid();  chk($sformatf("to_wait_ctl%0d", i), 32'(ctl), 32'(C_ZERO));
      tick(); chk($sformatf("to_halted%0d", i), 32'(halted), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("to_err", 32'(mem_timeout_err), 32'd1);
    chk("to_stall", 32'(stall_cycles), 32'd15);
    mem_req_C = 1'b0; halt_C = 1'b1; branch_taken_X = 1'b1;
    mid();  chk("halt_ctl", 32'(ctl), 32'(C_ZERO));
    tick(); chk("halt_nostall", 32'(stall_cycles), 32'd15);
    idle_inputs();
    resume = 1'b1;
    mid();  chk("resume_ctl", 32'(ctl), 32'(C_ZERO));
    tick(); chk("resume_halted", 32'(halted), 32'd0);
    resume = 1'b0;
    chk("resume_err", 32'(mem_timeout_err), 32'd1);
    mid();  chk("resume_run_ctl", 32'(ctl), 32'(C_ALL));
    tick();

    // Ready arrives on the last allowed wait cycle: no timeout
    mem_req_C = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    mem_ready = 1'b1;
    mid();  chk("edge_ready_ctl", 32'(ctl), 32'(C_ALL));
    tick(); chk("edge_halted", 32'(halted), 32'd0);
    chk("edge_stall", 32'(stall_cycles), 32'd23);
    idle_inputs();

    // Halt instruction, then reset while halted
    halt_C = 1'b1;
    mid();  chk("haltc_ctl", 32'(ctl), 32'(C_HALT));
    tick(); chk("haltc_halted", 32'(halted), 32'd1);
    chk("haltc_stall", 32'(stall_cycles), 32'd24);
    idle_inputs();
    mid();
    rst = 1'b1;
    #1;
    chk("rst2_ctl", 32'(ctl), 32'(C_ZERO));
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_stall", 32'(stall_cycles), 32'd0);
    chk("rst2_err", 32'(mem_timeout_err), 32'd0);
    tick();
    rst = 1'b0;
    mid();  chk("rst2_run_ctl", 32'(ctl), 32'(C_ALL));
    tick(); chk("rst2_run_stall", 32'(stall_cycles), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the three-register processor pipeline (FD, DE, EC). Each cycle it drives pc_write_enable and the write_enable_*/clear_* pins of every pipeline register from hazard and status inputs. It sequences multi-cycle memory waits, load-use bubbles, taken-branch squashes and halt. It also keeps a memory-timeout error flag and a saturating stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 8, maximum consecutive MEM_WAIT cycles before a forced halt (legal range 2..255)
STALL_CNT_W, 16, width of the stall_cycles counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
load_X  in  1  instruction in execute (DE register output) is a load
dest_X  in  4  destination register of that load
src_a_D  in  4  decode-stage source register A
src_a_vld_D  in  1  src_a_D is read
src_b_D  in  4  decode-stage source register B
src_b_vld_D  in  1  src_b_D is read
branch_taken_X  in  1  execute resolved a taken branch or jump
mem_req_C  in  1  commit stage has a memory access pending (load or store)
mem_ready  in  1  memory completes the access this cycle
halt_C  in  1  commit stage holds a HALT instruction
resume  in  1  leave HALT (debug/host pulse)
pc_write_enable  out  1  PC register update
write_enable_FD / write_enable_DE / write_enable_EC  out  1 each  register load enables
clear_FD / clear_DE / clear_EC  out  1 each  load NOP/zeros (clear has priority over write_enable in each register)
halted  out  1  state==HALT
mem_timeout_err  out  1  sticky, set on memory timeout
stall_cycles  out  STALL_CNT_W  saturating stall counter

Behaviour:
- States: RUN, MEM_WAIT, HALT. Reset: state=RUN, wait_cnt=0, mem_timeout_err=0, stall_cycles=0.
- Outputs are a combinational decode of state and inputs. While rst=1, all enables and clears are 0.
- Default in RUN: all write enables and pc_write_enable = 1; all clears = 0.
- RUN priority, highest first. Only the first matching case applies:
  1. halt_C: pc_we=0, we_FD=0, clear_FD=1, clear_DE=1, we_EC=1. Next state HALT.
  2. mem_req_C && !mem_ready: pc_we, we_FD, we_DE and we_EC all 0. Next state MEM_WAIT, wait_cnt<=0.
  3. branch_taken_X: pc_we=1 (target load), clear_FD=1, clear_DE=1, we_EC=1.
  4. Load-use: load_X && ((src_a_vld_D && src_a_D==dest_X) || (src_b_vld_D && src_b_D==dest_X)). Then pc_we=0, we_FD=0, clear_DE=1 (bubble), we_EC=1.
  - A match on register 0 still stalls; there is no special case for r0.
- MEM_WAIT:
  - mem_ready=1: all enables 1, next RUN. mem_ready wins over a timeout in the same cycle.
  - mem_ready=0: all enables 0 and wait_cnt++.
  - If mem_ready=0 and wait_cnt==MEM_TIMEOUT-1: next HALT, mem_timeout_err<=1.
- HALT: all enables and clears 0. resume=1 -> next RUN; outputs stay frozen during the resume cycle itself.
- halt_C, branch and load-use inputs are ignored outside RUN.
- stall_cycles: increments in any cycle with pc_write_enable=0 and state!=HALT. Saturates at all-ones. Cleared only by rst.
- mem_timeout_err is cleared only by rst.
- Reset asserted mid-MEM_WAIT or mid-HALT returns to RUN with counters cleared. There is no lingering stall.

Decomposition:
- common_def package: ctrl_state_t enum (RUN, MEM_WAIT, HALT) and a pipe_ctrl_t struct grouping the {we, clear} pairs for FD, DE and EC. The existing NOP constant stays in common_def.
- One sub-module, load_use_detect: purely combinational, takes load_X, dest_X and the sources, outputs stall_lu. Everything else lives in a single FSM module.

Test Plan:
- No hazards for 10 cycles -> all enables 1, clears 0, stall_cycles=0.
- load_X=1, dest_X=4'h3, src_b_D=4'h3, src_b_vld_D=1 for one cycle -> that cycle pc_we=0, we_FD=0, clear_DE=1, we_EC=1; stall_cycles=1 afterwards.
- branch_taken_X=1 together with a load-use match -> branch wins: clear_FD=clear_DE=1, pc_we=1, no stall counted.
- mem_req_C=1, mem_ready low for 3 cycles then high -> 4 cycles with all enables 0, resume on the ready cycle, stall_cycles=4.
- MEM_TIMEOUT=8, mem_req_C=1, mem_ready never -> halted=1 and mem_timeout_err=1 on the 9th cycle after the request; resume pulse -> RUN; err stays 1.
- halt_C=1 -> clear_FD=clear_DE=1, we_EC=1, halted next cycle. rst pulse while halted -> RUN, outputs default, counters 0.
